pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central sequencer for the 5-stage pipeline register bank. It merges hazard-unit requests (load-use stall, JALR flush), E-stage branch redirect, IMEM/DMEM wait and multi-cycle-execute handshakes into per-register enable/clear controls plus PC enable. It owns the post-reset pipeline fill, the multi-cycle-op wait state with a watchdog, and a saturating stall-cycle counter. It sits beside the hazard unit, which stays purely combinational.

Parameters:
RST_BUBBLES, 2, cycles of forced bubbles after RST deasserts (1..15).
MC_TIMEOUT, 64, max MC_BUSY cycles before fault (2..1023).
CNT_W, 16, width of the stall counter.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
HAZ_STALL  in  1  load-use stall request from hazard unit.
HAZ_FLUSH  in  1  JALR in D; redirect and squash fetch.
BR_TAKEN  in  1  branch resolved taken in E.
IMEM_WAIT  in  1  instruction fetch not ready.
DMEM_WAIT  in  1  data memory not ready; freeze whole pipe.
MC_START  in  1  multi-cycle op (div/mul) present in E, first cycle.
MC_DONE  in  1  multi-cycle result valid.
PC_EN  out  1  PC register load enable.
REDIRECT  out  1  PC mux takes redirect target.
FD_EN, DE_EN, EM_EN, MW_EN  out  1 each  pipeline register enables.
FD_CLR, DE_CLR, EM_CLR  out  1 each  load NOP into register (valid only with its EN=1).
MC_ERR  out  1  sticky watchdog fault.
STATE  out  2  00 INIT, 01 RUN, 10 MC_BUSY, 11 FAULT.
STALL_CNT  out  CNT_W  saturating count of cycles with PC_EN=0 in RUN/MC_BUSY.

Behaviour:
- Control outputs are combinational from state+inputs; state, counters and MC_ERR are registered.
- RST=1: next state INIT, bubble counter=0, MC counter=0, STALL_CNT=0, MC_ERR=0. Outputs while RST=1 or in INIT: PC_EN=0, REDIRECT=0, all EN=1, FD_CLR=DE_CLR=EM_CLR=1. RST mid-operation (any state) has identical effect.
- INIT: lasts exactly RST_BUBBLES cycles after RST falls, then RUN.
- RUN default: all EN=1, PC_EN=1, CLR=0, REDIRECT=0.
- RUN priority (highest first; one action per cycle):
  1. DMEM_WAIT: all EN=0, PC_EN=0, CLR=0. Other requests ignored; their sources are held and re-present next cycle.
  2. BR_TAKEN: PC_EN=1, REDIRECT=1, FD_CLR=1, DE_CLR=1. Overrides HAZ_STALL, HAZ_FLUSH, IMEM_WAIT, MC_START.
  3. MC_START: next state MC_BUSY, MC counter=0. This cycle: PC_EN=0, FD_EN=DE_EN=0, EM_EN=1 with EM_CLR=1, MW_EN=1.
  4. HAZ_STALL: PC_EN=0, FD_EN=0, DE_CLR=1. Overrides HAZ_FLUSH.
  5. HAZ_FLUSH: PC_EN=1, REDIRECT=1, FD_CLR=1.
  6. IMEM_WAIT: PC_EN=0, FD_CLR=1.
- MC_BUSY:
  - DMEM_WAIT: full freeze; MC counter holds.
  - MC_DONE: EM_EN=1 with EM_CLR=0, FD/DE/MW/PC enabled; next state RUN. MC_DONE in the MC_START cycle is ignored.
  - Otherwise: same controls as the MC_START cycle; MC counter +1.
  - Counter reaching MC_TIMEOUT-1 with no MC_DONE: next state FAULT.
  - BR_TAKEN and HAZ_* ignored.
- FAULT: MC_ERR=1, all EN=0, PC_EN=0. Only RST exits.
- STALL_CNT: +1 each cycle state∈{RUN, MC_BUSY} and PC_EN=0. Saturates at 2^CNT_W-1, no wrap.

Test Plan:
- RST high 3 cycles, release, RST_BUBBLES=2: STATE=00 and PC_EN=0 for 2 cycles after release; STATE=01, PC_EN=1, all CLR=0 on cycle 3.
- HAZ_STALL 1 cycle in RUN: PC_EN=0, FD_EN=0, DE_CLR=1, EM_EN=MW_EN=1; STALL_CNT 0→1. HAZ_STALL with BR_TAKEN same cycle: REDIRECT=1, FD_CLR=DE_CLR=1, PC_EN=1, no stall.
- DMEM_WAIT with BR_TAKEN for 3 cycles, then DMEM_WAIT drops: 3 cycles all EN=0, REDIRECT=0; 4th cycle REDIRECT=1.
- MC_START, MC_DONE 5 cycles later: STATE=10 for 5 cycles with EM_CLR=1; MC_DONE cycle EM_CLR=0, EM_EN=1; next STATE=01; STALL_CNT +6.
- MC_TIMEOUT=4, MC_START with MC_DONE never asserted: STATE=11 after 4 cycles in MC_BUSY; MC_ERR=1, all EN=0 and held; RST clears MC_ERR and returns to INIT.
- CNT_W=4, hold IMEM_WAIT 20 cycles: STALL_CNT saturates at 15; FD_CLR=1 every cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: folds hazard, redirect, memory-wait and multi-cycle-op
// requests into per-register enable/clear controls, PC enable and a stall counter.
module pipe_ctrl #(
    parameter int RST_BUBBLES = 2,
    parameter int MC_TIMEOUT  = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HAZ_STALL,
    input  logic             HAZ_FLUSH,
    input  logic             BR_TAKEN,
    input  logic             IMEM_WAIT,
    input  logic             DMEM_WAIT,
    input  logic             MC_START,
    input  logic             MC_DONE,
    output logic             PC_EN,
    output logic             REDIRECT,
    output logic             FD_EN,
    output logic             DE_EN,
    output logic             EM_EN,
    output logic             MW_EN,
    output logic             FD_CLR,
    output logic             DE_CLR,
    output logic             EM_CLR,
    output logic             MC_ERR,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_MC    = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [3:0] BUB_LAST = 4'(RST_BUBBLES - 1);
    localparam logic [9:0] MC_LAST  = 10'(MC_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [3:0]       bub_q, bub_d;
    logic [9:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mc_err_q, mc_err_d;

    always_comb begin
        state_d     = state_q;
        bub_d       = bub_q;
        mc_cnt_d    = mc_cnt_q;
        mc_err_d    = mc_err_q;
        stall_cnt_d = stall_cnt_q;
        PC_EN       = 1'b1;
        REDIRECT    = 1'b0;
        FD_EN       = 1'b1;
        DE_EN       = 1'b1;
        EM_EN       = 1'b1;
        MW_EN       = 1'b1;
        FD_CLR      = 1'b0;
        DE_CLR      = 1'b0;
        EM_CLR      = 1'b0;

        case (state_q)
            ST_INIT: begin
                PC_EN  = 1'b0;
                FD_CLR = 1'b1;
                DE_CLR = 1'b1;
                EM_CLR = 1'b1;
                if (bub_q == BUB_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    bub_d = bub_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (DMEM_WAIT) begin
                    PC_EN = 1'b0;
                    FD_EN = 1'b0;
                    DE_EN = 1'b0;
                    EM_EN = 1'b0;
                    MW_EN = 1'b0;
                end else if (BR_TAKEN) begin
                    REDIRECT = 1'b1;
                    FD_CLR   = 1'b1;
                    DE_CLR   = 1'b1;
                end else if (MC_START) begin
                    // Hold F/D/E, bubble into M while the op iterates in E
                    PC_EN    = 1'b0;
                    FD_EN    = 1'b0;
                    DE_EN    = 1'b0;
                    EM_CLR   = 1'b1;
                    state_d  = ST_MC;
                    mc_cnt_d = 10'd0;
                end else if (HAZ_STALL) begin
                    PC_EN  = 1'b0;
                    FD_EN  = 1'b0;
                    DE_CLR = 1'b1;
                end else if (HAZ_FLUSH) begin
                    REDIRECT = 1'b1;
                    FD_CLR   = 1'b1;
                end else if (IMEM_WAIT) begin
                    PC_EN  = 1'b0;
                    FD_CLR = 1'b1;
                end
            end
            ST_MC: begin
                if (DMEM_WAIT) begin
                    PC_EN = 1'b0;
                    FD_EN = 1'b0;
                    DE_EN = 1'b0;
                    EM_EN = 1'b0;
                    MW_EN = 1'b0;
                end else if (MC_DONE) begin
                    state_d = ST_RUN;
                end else begin
                    PC_EN  = 1'b0;
                    FD_EN  = 1'b0;
                    DE_EN  = 1'b0;
                    EM_CLR = 1'b1;
                    if (mc_cnt_q == MC_LAST) begin
                        state_d  = ST_FAULT;
                        mc_err_d = 1'b1;
                    end else begin
                        mc_cnt_d = mc_cnt_q + 10'd1;
                    end
                end
            end
            ST_FAULT: begin
                PC_EN    = 1'b0;
                FD_EN    = 1'b0;
                DE_EN    = 1'b0;
                EM_EN    = 1'b0;
                MW_EN    = 1'b0;
                mc_err_d = 1'b1;
            end
        endcase

        if ((state_q == ST_RUN || state_q == ST_MC) && !PC_EN && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Reset overrides everything, including a pending fault or freeze
        if (RST) begin
            state_d     = ST_INIT;
            bub_d       = 4'd0;
            mc_cnt_d    = 10'd0;
            stall_cnt_d = '0;
            mc_err_d    = 1'b0;
            PC_EN       = 1'b0;
            REDIRECT    = 1'b0;
            FD_EN       = 1'b1;
            DE_EN       = 1'b1;
            EM_EN       = 1'b1;
            MW_EN       = 1'b1;
            FD_CLR      = 1'b1;
            DE_CLR      = 1'b1;
            EM_CLR      = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        bub_q       <= bub_d;
        mc_cnt_q    <= mc_cnt_d;
        stall_cnt_q <= stall_cnt_d;
        mc_err_q    <= mc_err_d;
    end

    assign MC_ERR    = mc_err_q;
    assign STATE     = state_q;
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected outputs go into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int W = 17;

  localparam logic [7:0] I_NONE = 8'h00;
  localparam logic [7:0] I_RST  = 8'h80;
  localparam logic [7:0] I_HS   = 8'h40;
  localparam logic [7:0] I_HF   = 8'h20;
  localparam logic [7:0] I_BR   = 8'h10;
  localparam logic [7:0] I_IW   = 8'h08;
  localparam logic [7:0] I_DW   = 8'h04;
  localparam logic [7:0] I_MS   = 8'h02;
  localparam logic [7:0] I_MD   = 8'h01;

  // {PC_EN, REDIRECT, FD_EN, DE_EN, EM_EN, MW_EN, FD_CLR, DE_CLR, EM_CLR, MC_ERR}
  localparam logic [9:0] C_INIT = 10'b0_0_1111_111_0;
  localparam logic [9:0] C_RSTF = 10'b0_0_1111_111_1;
  localparam logic [9:0] C_RUN  = 10'b1_0_1111_000_0;
  localparam logic [9:0] C_FRZ  = 10'b0_0_0000_000_0;
  localparam logic [9:0] C_BR   = 10'b1_1_1111_110_0;
  localparam logic [9:0] C_MC   = 10'b0_0_0011_001_0;
  localparam logic [9:0] C_STL  = 10'b0_0_0111_010_0;
  localparam logic [9:0] C_HFL  = 10'b1_1_1111_100_0;
  localparam logic [9:0] C_IMW  = 10'b0_0_1111_100_0;
  localparam logic [9:0] C_FLT  = 10'b0_0_0000_000_1;

  localparam logic [1:0] S_INIT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_MC   = 2'b10;
  localparam logic [1:0] S_FLT  = 2'b11;

  logic CLK;
  logic RST, HAZ_STALL, HAZ_FLUSH, BR_TAKEN, IMEM_WAIT, DMEM_WAIT, MC_START, MC_DONE;
  logic PC_EN, REDIRECT, FD_EN, DE_EN, EM_EN, MW_EN, FD_CLR, DE_CLR, EM_CLR, MC_ERR;
  logic [1:0] STATE;
  logic [CNT_W-1:0] STALL_CNT;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pipe_ctrl #(.RST_BUBBLES(2), .MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .HAZ_STALL(HAZ_STALL), .HAZ_FLUSH(HAZ_FLUSH),
    .BR_TAKEN(BR_TAKEN), .IMEM_WAIT(IMEM_WAIT), .DMEM_WAIT(DMEM_WAIT),
    .MC_START(MC_START), .MC_DONE(MC_DONE), .PC_EN(PC_EN), .REDIRECT(REDIRECT),
    .FD_EN(FD_EN), .DE_EN(DE_EN), .EM_EN(EM_EN), .MW_EN(MW_EN),
    .FD_CLR(FD_CLR), .DE_CLR(DE_CLR), .EM_CLR(EM_CLR), .MC_ERR(MC_ERR),
    .STATE(STATE), .STALL_CNT(STALL_CNT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    {RST, HAZ_STALL, HAZ_FLUSH, BR_TAKEN, IMEM_WAIT, DMEM_WAIT, MC_START, MC_DONE} = I_RST;
  end

  // driver: apply one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input logic [7:0] in, input logic chk, input logic [1:0] st,
                      input logic [9:0] ctl, input logic [CNT_W-1:0] cnt);
    @(posedge CLK);
    #1;
    {RST, HAZ_STALL, HAZ_FLUSH, BR_TAKEN, IMEM_WAIT, DMEM_WAIT, MC_START, MC_DONE} = in;
    exp_q.push_back({chk, st, ctl, cnt});
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [W-2:0] act;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        act = {STATE, PC_EN, REDIRECT, FD_EN, DE_EN, EM_EN, MW_EN,
               FD_CLR, DE_CLR, EM_CLR, MC_ERR, STALL_CNT};
        if (e[W-1]) begin
          checks++;
          if (act !== e[W-2:0]) begin
            errors++;
            $display("FAIL cyc%0d: got state=%b ctl=%b cnt=%0d, expected state=%b ctl=%b cnt=%0d",
                     cyc, act[15:14], act[13:4], act[3:0], e[15:14], e[13:4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    // reset and pipeline fill
    step(I_RST, 1'b0, S_INIT, C_INIT, 4'd0);
    step(I_RST, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_RST, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd0);
    // hazard / redirect priorities
    step(I_HS, 1'b1, S_RUN, C_STL, 4'd0);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd1);
    step(I_HS | I_BR, 1'b1, S_RUN, C_BR, 4'd1);
    step(I_HF, 1'b1, S_RUN, C_HFL, 4'd1);
    step(I_HS | I_HF, 1'b1, S_RUN, C_STL, 4'd1);
    step(I_IW | I_HF, 1'b1, S_RUN, C_HFL, 4'd2);
    step(I_IW, 1'b1, S_RUN, C_IMW, 4'd2);
    // DMEM freeze holds a pending branch
    for (int i = 0; i < 3; i++) step(I_DW | I_BR, 1'b1, S_RUN, C_FRZ, 4'(3 + i));
    step(I_BR, 1'b1, S_RUN, C_BR, 4'd6);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd6);
    // multi-cycle op; MC_DONE in the start cycle is ignored
    step(I_MS | I_MD, 1'b1, S_RUN, C_MC, 4'd6);
    for (int i = 0; i < 5; i++) step(I_NONE, 1'b1, S_MC, C_MC, 4'(7 + i));
    step(I_MD | I_BR | I_HS, 1'b1, S_MC, C_RUN, 4'd12);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd12);
    // reset mid-run
    step(I_RST, 1'b1, S_RUN, C_INIT, 4'd12);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd0);
    // watchdog: freeze in MC_BUSY holds the counter, then timeout
    step(I_MS, 1'b1, S_RUN, C_MC, 4'd0);
    step(I_NONE, 1'b1, S_MC, C_MC, 4'd1);
    step(I_DW | I_MD, 1'b1, S_MC, C_FRZ, 4'd2);
    for (int i = 0; i < 6; i++) step(I_NONE, 1'b1, S_MC, C_MC, 4'(3 + i));
    step(I_NONE, 1'b1, S_MC, C_MC, 4'd9);
    step(I_MD, 1'b1, S_FLT, C_FLT, 4'd10);
    step(I_BR | I_HS, 1'b1, S_FLT, C_FLT, 4'd10);
    step(I_RST, 1'b1, S_FLT, C_RSTF, 4'd10);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd0);
    // stall counter saturation
    for (int i = 0; i < 20; i++) step(I_IW, 1'b1, S_RUN, C_IMW, (i > 15) ? 4'd15 : 4'(i));
    step(I_NONE, 1'b1, S_RUN, C_RUN, 4'd15);
    step(I_RST, 1'b1, S_RUN, C_INIT, 4'd15);
    step(I_NONE, 1'b1, S_INIT, C_INIT, 4'd0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
